// File: rtl/input_cmd_queue.sv
// rtl/input_cmd_queue.sv - serialises move pulses into a small show-ahead command FIFO
module input_cmd_queue #(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                      clk_in,
   input  logic                      reset_n_in,
   input  logic                      flush_in,
   input  logic [6:0]                pulse_in,
   input  logic                      cmd_ready_in,
   output logic                      cmd_valid_out,
   output logic [2:0]                cmd_out,
   output logic [$clog2(DEPTH):0]    count_out,
   output logic [6:0]                pending_out,
   output logic [DROP_W-1:0]         drop_count_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [2:0]        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [6:0]        pending_q, pending_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic [6:0]        eff, coal, sel;
   logic [2:0]        sel_code, n_coal;
   logic [DROP_W:0]   drop_sum;
   logic              push, pop;

   assign cmd_valid_out  = (count_q != '0);
   assign cmd_out        = cmd_valid_out ? mem_q[rd_ptr_q] : 3'd0;
   assign count_out      = count_q;
   assign pending_out    = pending_q;
   assign drop_count_out = drop_q;

   // Opposite moves cancel: LEFT and RIGHT together are discarded and never counted as drops.
   always_comb begin
      eff  = pending_q | pulse_in;
      coal = pending_q & pulse_in;
      if (eff[0] && eff[1]) begin
         eff[1:0]  = 2'b00;
         coal[1:0] = 2'b00;
      end
   end

   // Fixed priority: HARD > HOLD > ROT_CW > ROT_CCW > LEFT > RIGHT > SOFT
   always_comb begin
      sel      = 7'b0;
      sel_code = 3'd0;
      if (eff[5])      begin sel = 7'b0100000; sel_code = 3'd6; end
      else if (eff[6]) begin sel = 7'b1000000; sel_code = 3'd7; end
      else if (eff[2]) begin sel = 7'b0000100; sel_code = 3'd3; end
      else if (eff[3]) begin sel = 7'b0001000; sel_code = 3'd4; end
      else if (eff[0]) begin sel = 7'b0000001; sel_code = 3'd1; end
      else if (eff[1]) begin sel = 7'b0000010; sel_code = 3'd2; end
      else if (eff[4]) begin sel = 7'b0010000; sel_code = 3'd5; end
   end

   assign pop       = cmd_valid_out & cmd_ready_in;
   assign push      = (eff != 7'b0) & ((count_q < CW'(DEPTH)) | pop);
   assign pending_d = push ? (eff & ~sel) : eff;

   always_comb begin
      n_coal = 3'd0;
      for (int i = 0; i < 7; i++) begin
         n_coal = n_coal + {2'b00, coal[i]};
      end
      drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_coal);
      if (drop_sum > {1'b0, {DROP_W{1'b1}}}) begin
         drop_d = {DROP_W{1'b1}};
      end else begin
         drop_d = drop_sum[DROP_W-1:0];
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 3'd0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= 7'b0;
         drop_q    <= '0;
      end else if (flush_in) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= 7'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= sel_code;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
         pending_q <= pending_d;
         drop_q    <= drop_d;
      end
   end
endmodule

// File: tb/tb_input_cmd_queue.sv
// tb/tb_input_cmd_queue.sv - queue-model checked bench for input_cmd_queue
module tb_input_cmd_queue;
   logic       clk_in = 1'b0;
   logic       reset_n_in;
   logic       flush_in;
   logic [6:0] pulse_in;
   logic       cmd_ready_in;
   logic       cmd_valid_out;
   logic [2:0] cmd_out;
   logic [2:0] count_out;
   logic [6:0] pending_out;
   logic [7:0] drop_count_out;

   int total = 0;
   int bad   = 0;

   input_cmd_queue #(.DEPTH(4), .DROP_W(8)) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .flush_in(flush_in),
      .pulse_in(pulse_in), .cmd_ready_in(cmd_ready_in),
      .cmd_valid_out(cmd_valid_out), .cmd_out(cmd_out), .count_out(count_out),
      .pending_out(pending_out), .drop_count_out(drop_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: command queue, pending set and drop tally
   int         mq[$];
   logic [6:0] mpend;
   int         mdrop;
   logic [6:0] m_eff, m_coal;
   bit         m_pop;
   int         pri_order[7] = '{5, 6, 2, 3, 0, 1, 4};

   always @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         mq.delete();
         mpend = 7'b0;
         mdrop = 0;
      end else if (flush_in) begin
         mq.delete();
         mpend = 7'b0;
      end else begin
         m_eff  = mpend | pulse_in;
         m_coal = mpend & pulse_in;
         if (m_eff[0] && m_eff[1]) begin
            m_eff[1:0]  = 2'b00;
            m_coal[1:0] = 2'b00;
         end
         mdrop = mdrop + $countones(m_coal);
         if (mdrop > 255) mdrop = 255;
         m_pop = (mq.size() != 0) && cmd_ready_in;
         if (m_pop) void'(mq.pop_front());
         if (m_eff != 7'b0 && mq.size() < 4) begin
            for (int k = 0; k < 7; k++) begin
               if (m_eff[pri_order[k]]) begin
                  mq.push_back(pri_order[k] + 1);
                  m_eff[pri_order[k]] = 1'b0;
                  break;
               end
            end
         end
         mpend = m_eff;
      end
   end

   always @(negedge clk_in) begin
      if (reset_n_in) begin
         chk("m_valid", int'(cmd_valid_out), int'(mq.size() != 0));
         chk("m_cmd", int'(cmd_out), (mq.size() != 0) ? mq[0] : 0);
         chk("m_count", int'(count_out), mq.size());
         chk("m_pending", int'(pending_out), int'(mpend));
         chk("m_drop", int'(drop_count_out), mdrop);
      end
   end

   task automatic cyc(input logic [6:0] p, input logic r, input logic f);
      pulse_in     = p;
      cmd_ready_in = r;
      flush_in     = f;
      @(posedge clk_in);
      #2;
   endtask

   int n_rot;

   initial begin
      reset_n_in   = 1'b0;
      flush_in     = 1'b0;
      pulse_in     = 7'b0;
      cmd_ready_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #2;
      chk("rst_valid", int'(cmd_valid_out), 0);
      chk("rst_cmd", int'(cmd_out), 0);
      chk("rst_count", int'(count_out), 0);
      chk("rst_drop", int'(drop_count_out), 0);
      reset_n_in = 1'b1;

      // single ROT_CW, one-cycle latency then consumed
      cyc(7'b0000100, 1'b1, 1'b0);
      chk("t1_valid", int'(cmd_valid_out), 1);
      chk("t1_cmd", int'(cmd_out), 3);
      cyc(7'b0, 1'b1, 1'b0);
      chk("t1_empty", int'(cmd_valid_out), 0);

      // HARD|LEFT together: 6 first, LEFT pending one cycle
      cyc(7'b0100001, 1'b0, 1'b0);
      chk("t2_cmd", int'(cmd_out), 6);
      chk("t2_pend", int'(pending_out), 1);
      cyc(7'b0, 1'b0, 1'b0);
      chk("t2_pend0", int'(pending_out), 0);
      chk("t2_count", int'(count_out), 2);
      cyc(7'b0, 1'b1, 1'b0);
      chk("t2_cmd2", int'(cmd_out), 1);
      cyc(7'b0, 1'b1, 1'b0);

      // LEFT then RIGHT while full cancel each other
      repeat (4) cyc(7'b0010000, 1'b0, 1'b0);
      cyc(7'b0000001, 1'b0, 1'b0);
      chk("t3_pendL", int'(pending_out), 1);
      cyc(7'b0000010, 1'b0, 1'b0);
      chk("t3_pend0", int'(pending_out), 0);
      chk("t3_count", int'(count_out), 4);
      chk("t3_drop", int'(drop_count_out), 0);
      repeat (4) cyc(7'b0, 1'b1, 1'b0);

      // ROT_CW overflow into pending, then coalesce
      repeat (4) cyc(7'b0000100, 1'b0, 1'b0);
      cyc(7'b0000100, 1'b0, 1'b0);
      chk("t4_count", int'(count_out), 4);
      chk("t4_pend", int'(pending_out), 4);
      cyc(7'b0000100, 1'b0, 1'b0);
      chk("t4_drop", int'(drop_count_out), 1);
      n_rot = 0;
      for (int i = 0; i < 8; i++) begin
         if (cmd_valid_out && cmd_out == 3'd3) n_rot++;
         cyc(7'b0, 1'b1, 1'b0);
      end
      chk("t4_nrot", n_rot, 5);

      // full FIFO with continuous SOFT and ready
      repeat (4) cyc(7'b0010000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(7'b0010000, 1'b1, 1'b0);
         chk("t5_count", int'(count_out), 4);
      end
      repeat (5) cyc(7'b0, 1'b1, 1'b0);

      // flush with entries queued and a pending bit
      cyc(7'b0010000, 1'b0, 1'b0);
      cyc(7'b0010000, 1'b0, 1'b0);
      cyc(7'b1100000, 1'b0, 1'b0);
      chk("t6_count", int'(count_out), 3);
      chk("t6_pend", int'(pending_out), 7'h40);
      cyc(7'b0001000, 1'b0, 1'b1);
      chk("t6_fcount", int'(count_out), 0);
      chk("t6_fvalid", int'(cmd_valid_out), 0);
      chk("t6_fpend", int'(pending_out), 0);
      chk("t6_fdrop", int'(drop_count_out), 1);
      cyc(7'b0, 1'b0, 1'b0);
      chk("t6_after", int'(cmd_valid_out), 0);

      // asynchronous reset mid-stream
      cyc(7'b0010000, 1'b0, 1'b0);
      cyc(7'b0010000, 1'b0, 1'b0);
      reset_n_in = 1'b0;
      #1;
      chk("ar_valid", int'(cmd_valid_out), 0);
      chk("ar_cmd", int'(cmd_out), 0);
      chk("ar_count", int'(count_out), 0);
      chk("ar_pend", int'(pending_out), 0);
      chk("ar_drop", int'(drop_count_out), 0);
      @(posedge clk_in);
      #2;
      reset_n_in = 1'b1;
      cyc(7'b0, 1'b1, 1'b0);
      chk("ar_quiet", int'(cmd_valid_out), 0);

      // drop counter saturation
      repeat (50) cyc(7'b1111101, 1'b0, 1'b0);
      chk("sat_drop", int'(drop_count_out), 255);
      chk("sat_pend", int'(pending_out), 7'h7D);
      chk("sat_count", int'(count_out), 4);

      @(posedge clk_in);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
